// File: rtl/barrier_gen_pkg.sv
// Shared definitions for the scrolling obstacle generator: field width,
// controller states and the LFSR polynomial used to place obstacles.
package barrier_gen_pkg;

    localparam int BARRIER_W = 40;

    // Default LFSR start value; must never be zero or the LFSR locks up.
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Feedback taps on bits 7, 5, 4 and 3 (x^8 + x^6 + x^5 + x^4 + 1).
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // One shift of the LFSR: old bits move up, parity of the taps enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a slow level signal sampled on the system clock.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev;

    // Remember last cycle's level so a low-to-high change can be spotted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/barrier_gen.sv
// Obstacle field generator: on every scroll step the field shifts one column,
// an LFSR decides whether a new obstacle enters (subject to a minimum gap),
// and obstacles falling off the far end are counted as score.
module barrier_gen
    import barrier_gen_pkg::*;
#(
    parameter int         MIN_GAP = 3,
    parameter logic [7:0] SEED    = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 barrier_clock,
    input  logic                 start,
    input  logic                 hit,
    output logic [BARRIER_W-1:0] barrier,
    output logic [7:0]           score,
    output logic                 running
);

    localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] next_lfsr;
    logic [7:0] gap;
    logic       step;
    logic       new_bit;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (barrier_clock),
        .rise (step)
    );

    assign next_lfsr = lfsr_next(lfsr);

    // A new obstacle needs both a lucky LFSR draw and enough empty columns behind it.
    assign new_bit = (next_lfsr[1:0] == 2'b00) && (gap >= GAP_MAX);

    assign running = (state == RUN);

    // Controller plus all game state: hit beats a step, start restarts a fresh field.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            barrier <= '0;
            score   <= 8'h00;
            lfsr    <= SEED;
            gap     <= GAP_MAX;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= RUN;
                        barrier <= '0;
                        score   <= 8'h00;
                        gap     <= GAP_MAX;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state <= HALT;
                    end else if (step) begin
                        lfsr    <= next_lfsr;
                        barrier <= {barrier[BARRIER_W-2:0], new_bit};
                        if (new_bit) begin
                            gap <= 8'd0;
                        end else if (gap < GAP_MAX) begin
                            gap <= gap + 8'd1;
                        end
                        if (barrier[BARRIER_W-1] && (score != 8'hFF)) begin
                            score <= score + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrier_gen.sv
// Self-checking bench for barrier_gen: a directed vector table for the reset
// and LFSR start-up sequence, hand-written hit/restart/score/reset sequences,
// and long randomized runs compared against a column-queue reference model.
module tb_barrier_gen;
    import barrier_gen_pkg::*;

    localparam int         MIN_GAP = 3;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         M_IDLE  = 0;
    localparam int         M_RUN   = 1;
    localparam int         M_HALT  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 barrier_clock;
    logic                 start;
    logic                 hit;
    logic [BARRIER_W-1:0] barrier;
    logic [7:0]           score;
    logic                 running;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: obstacle columns kept in a queue, newest at index 0.
    int         m_state;
    bit         m_prev;
    logic [7:0] m_lfsr;
    bit         m_cols[$];
    int         m_score;
    bit         m_stepped;

    typedef struct {
        bit                   r;
        bit                   b;
        bit                   s;
        bit                   h;
        logic [BARRIER_W-1:0] eb;
        logic [7:0]           es;
        bit                   er;
        logic [7:0]           el;
        string                name;
    } vec_t;

    vec_t vecs[$];

    barrier_gen #(
        .MIN_GAP (MIN_GAP),
        .SEED    (SEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .barrier_clock (barrier_clock),
        .start         (start),
        .hit           (hit),
        .barrier       (barrier),
        .score         (score),
        .running       (running)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Advance the model by one clock edge with the given inputs.
    function automatic void model_clock(input bit r, input bit b, input bit s, input bit h);
        bit step;
        bit clear;
        bit fb;
        bit nb;
        m_stepped = 1'b0;
        if (r) begin
            m_state = M_IDLE;
            m_prev  = 1'b0;
            m_lfsr  = SEED;
            m_cols.delete();
            m_score = 0;
            return;
        end
        step   = b && !m_prev;
        m_prev = b;
        if (m_state == M_RUN) begin
            if (h) begin
                m_state = M_HALT;
            end else if (step) begin
                fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
                m_lfsr = {m_lfsr[6:0], fb};
                clear  = 1'b1;
                for (int k = 0; k < MIN_GAP && k < m_cols.size(); k++) begin
                    if (m_cols[k]) clear = 1'b0;
                end
                nb = (m_lfsr % 4 == 0) && clear;
                if (m_cols.size() == BARRIER_W && m_cols[BARRIER_W-1] && m_score < 255)
                    m_score++;
                m_cols.push_front(nb);
                if (m_cols.size() > BARRIER_W) void'(m_cols.pop_back());
                m_stepped = 1'b1;
            end
        end else if (s) begin
            m_state = M_RUN;
            m_cols.delete();
            m_score = 0;
        end
    endfunction

    function automatic logic [BARRIER_W-1:0] model_barrier();
        logic [BARRIER_W-1:0] v;
        v = '0;
        for (int i = 0; i < m_cols.size(); i++) v[i] = m_cols[i];
        return v;
    endfunction

    // True when every pair of obstacles is separated by at least MIN_GAP empty columns.
    function automatic bit gap_ok(input logic [BARRIER_W-1:0] v);
        int last;
        last = -100;
        for (int i = 0; i < BARRIER_W; i++) begin
            if (v[i]) begin
                if (i - last - 1 < MIN_GAP) return 1'b0;
                last = i;
            end
        end
        return 1'b1;
    endfunction

    function automatic void addVec(input bit r, input bit b, input bit s, input bit h,
                                   input logic [BARRIER_W-1:0] eb, input logic [7:0] es,
                                   input bit er, input logic [7:0] el, input string name);
        vec_t v;
        v.r = r; v.b = b; v.s = s; v.h = h;
        v.eb = eb; v.es = es; v.er = er; v.el = el; v.name = name;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, advance the model, and settle just after the edge.
    task automatic applyStimulus(input bit r, input bit b, input bit s, input bit h);
        rst           = r;
        barrier_clock = b;
        start         = s;
        hit           = h;
        model_clock(r, b, s, h);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the model in a single comparison.
    task automatic checkModel(input string name);
        logic [63:0] act;
        logic [63:0] exp;
        act = 64'({barrier, score, running});
        exp = 64'({model_barrier(), m_score[7:0], (m_state == M_RUN)});
        checkOutput(name, act, exp);
    endtask

    task automatic doStep();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int steps;
        int cyc;
        logic [BARRIER_W-1:0] pre;

        rst = 1'b1; barrier_clock = 1'b0; start = 1'b0; hit = 1'b0;

        // Reset, IDLE toggling, start, the first five steps, hit-vs-step, restart.
        addVec(1, 0, 0, 0, 40'h0, 8'h00, 0, 8'hA5, "reset cycle 1");
        addVec(1, 0, 0, 0, 40'h0, 8'h00, 0, 8'hA5, "reset cycle 2");
        addVec(0, 1, 0, 0, 40'h0, 8'h00, 0, 8'hA5, "idle bc high");
        addVec(0, 0, 0, 0, 40'h0, 8'h00, 0, 8'hA5, "idle bc low");
        addVec(0, 1, 0, 0, 40'h0, 8'h00, 0, 8'hA5, "idle bc high again");
        addVec(0, 0, 1, 0, 40'h0, 8'h00, 1, 8'hA5, "start to run");
        addVec(0, 1, 0, 0, 40'h0, 8'h00, 1, 8'h4A, "step 1");
        addVec(0, 0, 0, 0, 40'h0, 8'h00, 1, 8'h4A, "step 1 low");
        addVec(0, 1, 0, 0, 40'h0, 8'h00, 1, 8'h95, "step 2");
        addVec(0, 0, 0, 0, 40'h0, 8'h00, 1, 8'h95, "step 2 low");
        addVec(0, 1, 0, 0, 40'h0, 8'h00, 1, 8'h2A, "step 3");
        addVec(0, 0, 0, 0, 40'h0, 8'h00, 1, 8'h2A, "step 3 low");
        addVec(0, 1, 0, 0, 40'h1, 8'h00, 1, 8'h54, "step 4");
        addVec(0, 0, 0, 0, 40'h1, 8'h00, 1, 8'h54, "step 4 low");
        addVec(0, 1, 0, 0, 40'h2, 8'h00, 1, 8'hA9, "step 5");
        addVec(0, 0, 0, 0, 40'h2, 8'h00, 1, 8'hA9, "step 5 low");
        addVec(0, 1, 0, 1, 40'h2, 8'h00, 0, 8'hA9, "hit with step");
        addVec(0, 0, 1, 0, 40'h0, 8'h00, 1, 8'hA9, "restart from halt");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].b, vecs[i].s, vecs[i].h);
            checkOutput({vecs[i].name, " barrier"}, 64'(barrier), 64'(vecs[i].eb));
            checkOutput({vecs[i].name, " score"}, 64'(score), 64'(vecs[i].es));
            checkOutput({vecs[i].name, " running"}, 64'(running), 64'(vecs[i].er));
            checkOutput({vecs[i].name, " lfsr"}, 64'(dut.lfsr), 64'(vecs[i].el));
        end

        // Build a nonzero field, then hit+start together, a step in HALT, and restart.
        steps = 0;
        while (model_barrier() == '0 && steps < 200) begin
            doStep();
            steps++;
        end
        checkOutput("field nonzero before hit", 64'(barrier != '0), 64'd1);
        pre = model_barrier();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("hit+start running", 64'(running), 64'd0);
        checkOutput("hit+start barrier", 64'(barrier), 64'(pre));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("halt step ignored", 64'(barrier), 64'(pre));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("restart barrier", 64'(barrier), 64'd0);
        checkOutput("restart score", 64'(score), 64'd0);
        checkOutput("restart running", 64'(running), 64'd1);

        // Walk the first obstacle to the far end; one more step scores exactly one.
        steps = 0;
        while (!(m_cols.size() == BARRIER_W && m_cols[BARRIER_W-1]) && steps < 400) begin
            doStep();
            steps++;
        end
        checkOutput("obstacle at bit 39", 64'(barrier[BARRIER_W-1]), 64'd1);
        checkOutput("score before exit", 64'(score), 64'd0);
        doStep();
        checkOutput("score after exit", 64'(score), 64'd1);
        checkModel("model after exit");

        // Long random-rate run: gap rule every step, model every step, score saturates.
        steps = 0;
        cyc   = 0;
        while (steps < 4000 && cyc < 40000) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc++;
            if (m_stepped) begin
                steps++;
                checkOutput("gap rule", 64'(gap_ok(barrier)), 64'd1);
                checkModel("long run model");
            end
        end
        checkOutput("long run step budget", 64'(steps), 64'd4000);
        checkOutput("score saturated", 64'(score), 64'd255);

        // Reset in the middle of a run restores every register.
        checkOutput("field nonzero before reset", 64'(barrier != '0), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("mid-run reset barrier", 64'(barrier), 64'd0);
        checkOutput("mid-run reset score", 64'(score), 64'd0);
        checkOutput("mid-run reset running", 64'(running), 64'd0);
        checkOutput("mid-run reset lfsr", 64'(dut.lfsr), 64'(SEED));
        checkOutput("mid-run reset gap", 64'(dut.gap), 64'(MIN_GAP));
        checkOutput("mid-run reset edge reg", 64'(dut.u_edge.prev), 64'd0);

        // Mixed random traffic: starts, hits and occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 39) == 0));
            checkModel("random mix model");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrier_gen.md
BARRIER_GEN -- requirements
Module: barrier_gen

Interface
REQ-001 SHALL have parameter MIN_GAP, default 3, giving the minimum count of empty columns between two obstacles.
REQ-002 SHALL have parameter SEED, default 8'hA5, giving the LFSR reset value; a zero value is illegal.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port barrier_clock, input, 1, a level scroll-rate signal from the divider, sampled on clk.
REQ-006 SHALL have port start, input, 1, a start/restart request, one clk cycle or longer.
REQ-007 SHALL have port hit, input, 1, the collision flag from display.
REQ-008 SHALL have port barrier, output, 40, the obstacle field consumed by display; bit 0 is the newest column.
REQ-009 SHALL have port score, output, 8, the count of obstacles that have passed.
REQ-010 SHALL have port running, output, 1, high while in RUN.

Function
REQ-011 SHALL define a step as one clk cycle in which barrier_clock is high and its previously registered value is low.
REQ-012 SHALL implement the states IDLE, RUN and HALT.
- IDLE: start moves to RUN.
- RUN: hit moves to HALT.
- HALT: start moves to RUN.
REQ-013 SHALL, on any start-driven entry to RUN, clear barrier and score and set the gap counter to MIN_GAP in the same edge; the LFSR SHALL NOT be reseeded.
REQ-014 SHALL, on a step in RUN with hit low, advance the LFSR by one position: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-015 SHALL compute new_bit = (next_lfsr[1:0]==2'b00) && (gap >= MIN_GAP).
REQ-016 SHALL, on that step, shift the field: barrier <= {barrier[38:0], new_bit}.
REQ-017 SHALL update the gap counter on that step: reset to 0 when new_bit is 1, otherwise increment, saturating at MIN_GAP.
REQ-018 SHALL increment score on that step when barrier[39] was 1, saturating at 8'd255.
REQ-019 SHALL, when hit and a step coincide in RUN, let hit win: no shift, no LFSR advance, no score change.
REQ-020 SHALL hold barrier, score and the LFSR frozen in IDLE and HALT; steps there are ignored.
REQ-021 SHALL ignore hit outside RUN.
REQ-022 SHALL, when start and hit are both high in RUN, take the hit and go to HALT.
REQ-023 SHALL make all outputs registered, with their update visible the cycle after the qualifying edge.
REQ-024 SHALL drive running combinationally from the state register only.

Reset
REQ-025 SHALL, with rst high at a clk edge, set state=IDLE, barrier=40'h0, score=8'h00, running=0, lfsr=SEED, gap=MIN_GAP and the edge register=0.
REQ-026 SHALL give rst priority over start, hit and steps, including mid-RUN.
REQ-027 SHALL treat the first barrier_clock rise after reset release as a step only if barrier_clock was sampled low after reset.

Structure
REQ-028 SHALL place the following in a shared package:
- BARRIER_W=40
- the state encoding (IDLE/RUN/HALT)
- the LFSR tap constants
- the default SEED
REQ-029 SHALL implement the rising-edge detector as one sub-module, edge_detect (clk, rst, in, rise), reused by the controll path.
REQ-030 SHALL keep the LFSR, gap counter, field register, score and FSM in barrier_gen itself.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles, then idle -> barrier=0, score=0, running=0; barrier_clock toggling in IDLE leaves barrier=0.
REQ-032 SHALL cover the LFSR sequence: start, then 4 steps from SEED A5 -> the LFSR sequence is 4A,95,2A,54 and barrier=40'h1 after step 4; step 5 -> barrier=40'h2.
REQ-033 SHALL cover the gap rule: run 2000 steps -> between any two 1s in barrier there are at least MIN_GAP=3 zeros, checked every step.
REQ-034 SHALL cover scoring: run until the first obstacle reaches bit 39, then 1 more step -> score increments by exactly 1; preload a long run -> score stops at 255.
REQ-035 SHALL cover hit and restart:
- hit on the same cycle as a step -> barrier is unchanged and running=0.
- hit and start together in RUN -> HALT.
- start in HALT -> barrier=0, score=0, running=1.
REQ-036 SHALL cover reset mid-RUN: assert rst with barrier nonzero -> all registers return to the REQ-025 values on the next edge.
